// File: rtl/pmd901_speed_sched.sv
// Speed-command scheduler for the PMD901 SPI speed register: host/safety arbitration,
// bounded-step ramping paced to UPDATE_PERIOD. Optional watchdog: PMD901_SPEED_WDT_EN.
module pmd901_speed_sched #(
  parameter logic [11:0] UPDATE_PERIOD = 12'd2001,
  parameter logic [15:0] RAMP_STEP     = 16'd64,
  parameter logic [23:0] WDT_CYCLES    = 24'd10_000_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [15:0] host_speed,
  input  logic        safe_valid,
  output logic        safe_ready,
  input  logic [15:0] safe_speed,
  input  logic        safe_release,
  output logic [15:0] wdata,
  output logic        we,
  output logic [15:0] cur_speed,
  output logic        busy,
  output logic        safe_lock,
  output logic        wdt_trip
);

  typedef enum logic {SETTLED, RAMPING} state_t;

  if (UPDATE_PERIOD < 12'd2 || RAMP_STEP == 16'd0 || WDT_CYCLES == 24'd0) begin : g_cfg_check
    $error("pmd901_speed_sched: invalid parameter set");
  end

  state_t             state, state_next;
  logic        [11:0] tick_cnt;
  logic signed [15:0] target, target_next;
  logic signed [15:0] cur_q, cur_next;
  logic               lock_next;
  logic               tick;
  logic               host_acc;
  logic               wdt_force;
  logic               we_next;
  logic signed [16:0] diff, step_pos, step_neg, clamp, sum;

  assign tick       = (tick_cnt == UPDATE_PERIOD - 12'd1);
  assign host_ready = !safe_valid && !safe_lock;
  assign host_acc   = host_valid && host_ready;
  assign safe_ready = 1'b1;
  assign cur_speed  = cur_q;

`ifdef PMD901_SPEED_WDT_EN
  logic [23:0] wdt_cnt;
  logic        wdt_hit;

  assign wdt_hit   = (wdt_cnt == WDT_CYCLES - 24'd1);
  assign wdt_force = wdt_hit && !safe_lock;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wdt_cnt  <= '0;
      wdt_trip <= 1'b0;
    end else if (host_acc) begin
      wdt_cnt  <= '0;
      wdt_trip <= 1'b0;
    end else if (wdt_hit) begin
      wdt_cnt  <= '0;
      wdt_trip <= 1'b1;
    end else begin
      wdt_cnt  <= wdt_cnt + 24'd1;
    end
  end
`else
  assign wdt_force = 1'b0;
  assign wdt_trip  = 1'b0;
`endif

  // 17-bit signed difference cannot overflow; clamping keeps the sum between cur and target
  always_comb begin
    diff     = {target[15], target} - {cur_q[15], cur_q};
    step_pos = {1'b0, RAMP_STEP};
    step_neg = -step_pos;
    if (diff > step_pos)      clamp = step_pos;
    else if (diff < step_neg) clamp = step_neg;
    else                      clamp = diff;
    sum = {cur_q[15], cur_q} + clamp;
  end

  always_comb begin
    target_next = target;
    if (wdt_force)  target_next = '0;
    if (host_acc)   target_next = host_speed;
    if (safe_valid) target_next = safe_speed;

    we_next  = tick && (diff != 17'sd0);
    cur_next = we_next ? sum[15:0] : cur_q;

    lock_next = safe_lock;
    if (safe_valid)        lock_next = 1'b1;
    else if (safe_release) lock_next = 1'b0;
  end

  // FSM looks at the post-edge target/speed so busy tracks target != cur_speed without lag
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      SETTLED: begin
        if (target_next != cur_next) state_next = RAMPING;
      end
      RAMPING: begin
        busy = 1'b1;
        if (target_next == cur_next) state_next = SETTLED;
      end
      default: state_next = SETTLED;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= SETTLED;
      tick_cnt  <= '0;
      target    <= '0;
      cur_q     <= '0;
      wdata     <= '0;
      we        <= 1'b0;
      safe_lock <= 1'b0;
    end else begin
      state     <= state_next;
      tick_cnt  <= tick ? '0 : tick_cnt + 12'd1;
      target    <= target_next;
      cur_q     <= cur_next;
      we        <= we_next;
      safe_lock <= lock_next;
      if (we_next) wdata <= sum[15:0];
    end
  end

endmodule

// File: tb/tb_pmd901_speed_sched.sv
// Directed bench for pmd901_speed_sched: ramp, clamping, safety arbitration, full-scale swing,
// retargeting, watchdog (when PMD901_SPEED_WDT_EN is defined) and asynchronous reset.
module tb_pmd901_speed_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic        h_valid [3];
  logic        h_ready [3];
  logic [15:0] h_speed [3];
  logic        s_valid [3];
  logic        s_ready [3];
  logic [15:0] s_speed [3];
  logic        s_release [3];
  logic [15:0] wdata [3];
  logic        we [3];
  logic [15:0] cur [3];
  logic        busy [3];
  logic        lock [3];
  logic        trip [3];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int last_we [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: nominal ramp, 1: unbounded step, 2: short watchdog
  pmd901_speed_sched #(.UPDATE_PERIOD(12'd10), .RAMP_STEP(16'd100)) u_dut (
    .clk(clk), .rstn(rstn),
    .host_valid(h_valid[0]), .host_ready(h_ready[0]), .host_speed(h_speed[0]),
    .safe_valid(s_valid[0]), .safe_ready(s_ready[0]), .safe_speed(s_speed[0]),
    .safe_release(s_release[0]), .wdata(wdata[0]), .we(we[0]), .cur_speed(cur[0]),
    .busy(busy[0]), .safe_lock(lock[0]), .wdt_trip(trip[0]));

  pmd901_speed_sched #(.UPDATE_PERIOD(12'd10), .RAMP_STEP(16'hFFFF)) u_big (
    .clk(clk), .rstn(rstn),
    .host_valid(h_valid[1]), .host_ready(h_ready[1]), .host_speed(h_speed[1]),
    .safe_valid(s_valid[1]), .safe_ready(s_ready[1]), .safe_speed(s_speed[1]),
    .safe_release(s_release[1]), .wdata(wdata[1]), .we(we[1]), .cur_speed(cur[1]),
    .busy(busy[1]), .safe_lock(lock[1]), .wdt_trip(trip[1]));

  pmd901_speed_sched #(.UPDATE_PERIOD(12'd10), .RAMP_STEP(16'd100), .WDT_CYCLES(24'd50)) u_wdt (
    .clk(clk), .rstn(rstn),
    .host_valid(h_valid[2]), .host_ready(h_ready[2]), .host_speed(h_speed[2]),
    .safe_valid(s_valid[2]), .safe_ready(s_ready[2]), .safe_speed(s_speed[2]),
    .safe_release(s_release[2]), .wdata(wdata[2]), .we(we[2]), .cur_speed(cur[2]),
    .busy(busy[2]), .safe_lock(lock[2]), .wdt_trip(trip[2]));

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance to the next write strobe of instance idx (bounded) and check its value
  task automatic wait_we(input int idx, input int exp, input string tag, input bit spacing);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (we[idx] !== 1'b1 && n < 30);
    chk({tag, "_we"}, 32'(we[idx]), 1);
    chk({tag, "_wdata"}, $signed(wdata[idx]), exp);
    chk({tag, "_cur"}, $signed(cur[idx]), exp);
    if (spacing) chk({tag, "_spacing"}, cyc - last_we[idx], 10);
    last_we[idx] = cyc;
  endtask

  task automatic host_req(input int idx, input logic [15:0] speed);
    h_valid[idx] = 1'b1;
    h_speed[idx] = speed;
    @(negedge clk);
    h_valid[idx] = 1'b0;
  endtask

  task automatic chk_cleared(input int idx, input string tag);
    chk({tag, "_wdata"}, $signed(wdata[idx]), 0);
    chk({tag, "_we"}, 32'(we[idx]), 0);
    chk({tag, "_cur"}, $signed(cur[idx]), 0);
    chk({tag, "_busy"}, 32'(busy[idx]), 0);
    chk({tag, "_lock"}, 32'(lock[idx]), 0);
    chk({tag, "_trip"}, 32'(trip[idx]), 0);
    chk({tag, "_host_ready"}, 32'(h_ready[idx]), 1);
  endtask

  initial begin
    int rel;
    int acc;
    int cnt;
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      h_valid[i] = 1'b0; h_speed[i] = '0; s_valid[i] = 1'b0;
      s_speed[i] = '0; s_release[i] = 1'b0; last_we[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk_cleared(0, "reset");
    chk("reset_safe_ready", 32'(s_ready[0]), 1);

    // 1: host 250 accepted on the first edge after release
    rstn = 1'b1;
    rel = cyc;
    host_req(0, 16'd250);
    chk("t1_busy_up", 32'(busy[0]), 1);
    wait_we(0, 100, "t1_w100", 1'b0);
    chk("t1_first_write_latency", cyc - rel, 10);
    wait_we(0, 200, "t1_w200", 1'b1);
    wait_we(0, 250, "t1_w250", 1'b1);
    chk("t1_busy_down", 32'(busy[0]), 0);
    cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (we[0] === 1'b1) cnt++;
    end
    chk("t1_no_extra_we", cnt, 0);

    // 2: signed descent 250 -> -50
    host_req(0, 16'hFFCE);
    chk("t2_busy_up", 32'(busy[0]), 1);
    wait_we(0, 150, "t2_w150", 1'b0);
    wait_we(0, 50, "t2_w50", 1'b1);
    wait_we(0, -50, "t2_wm50", 1'b1);
    chk("t2_busy_down", 32'(busy[0]), 0);

    // 3: safety arbitration, started just after a tick so no write intervenes
    h_valid[0] = 1'b1; h_speed[0] = 16'd500; s_valid[0] = 1'b1; s_speed[0] = 16'd0;
    #1;
    chk("t3_host_ready_vs_safe", 32'(h_ready[0]), 0);
    chk("t3_safe_ready", 32'(s_ready[0]), 1);
    @(negedge clk);
    chk("t3_lock_set", 32'(lock[0]), 1);
    chk("t3_busy", 32'(busy[0]), 1);
    s_valid[0] = 1'b0;
    #1;
    chk("t3_host_refused", 32'(h_ready[0]), 0);
    @(negedge clk);
    s_valid[0] = 1'b1; s_release[0] = 1'b1;
    @(negedge clk);
    chk("t3_release_vs_valid", 32'(lock[0]), 1);
    s_valid[0] = 1'b0; h_valid[0] = 1'b0;
    @(negedge clk);
    chk("t3_released", 32'(lock[0]), 0);
    chk("t3_host_ready_back", 32'(h_ready[0]), 1);
    s_release[0] = 1'b0;
    wait_we(0, 0, "t3_w0", 1'b1);
    chk("t3_busy_down", 32'(busy[0]), 0);

    // 5: retarget mid-ramp from 200 (target 1000) to 230
    host_req(0, 16'd1000);
    wait_we(0, 100, "t5_w100", 1'b0);
    wait_we(0, 200, "t5_w200", 1'b1);
    host_req(0, 16'd230);
    wait_we(0, 230, "t5_w230", 1'b1);
    chk("t5_busy_down", 32'(busy[0]), 0);

    // 4: full-scale swing with unbounded step
    host_req(1, 16'h7FFF);
    wait_we(1, 32767, "t4_wmax", 1'b0);
    host_req(1, 16'h8000);
    wait_we(1, -32768, "t4_wmin", 1'b1);
    chk("t4_busy_down", 32'(busy[1]), 0);

    // 6: host silence after reaching 300
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    host_req(2, 16'd300);
    acc = cyc;
    wait_we(2, 100, "t6_w100", 1'b0);
    wait_we(2, 200, "t6_w200", 1'b1);
    wait_we(2, 300, "t6_w300", 1'b1);
`ifdef PMD901_SPEED_WDT_EN
    cnt = 0;
    while (trip[2] !== 1'b1 && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    chk("t6_trip", 32'(trip[2]), 1);
    chk("t6_trip_cycle", cyc - acc, 50);
    wait_we(2, 200, "t6_wdt_w200", 1'b0);
    wait_we(2, 100, "t6_wdt_w100", 1'b1);
    wait_we(2, 0, "t6_wdt_w0", 1'b1);
    host_req(2, 16'd0);
    chk("t6_trip_cleared", 32'(trip[2]), 0);
    host_req(2, 16'd300);
    wait_we(2, 100, "t6_rst_w100", 1'b0);
`else
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (we[2] === 1'b1 || trip[2] === 1'b1) cnt++;
    end
    chk("t6_no_wdt_activity", cnt, 0);
    chk("t6_speed_held", $signed(cur[2]), 300);
    host_req(2, 16'd0);
    wait_we(2, 200, "t6_rst_w200", 1'b0);
`endif
    chk("t6_busy_mid_ramp", 32'(busy[2]), 1);
    #2;
    rstn = 1'b0;
    #1;
    chk_cleared(2, "t6_async_reset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
